// File: rtl/line_collector.sv
// Line collector: assembles ASCII bytes into a right-justified line buffer,
// handles backspace/escape editing and strobes START to a downstream converter.
module line_collector #(
  parameter int STR_WIDTH = 512
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [7:0]           RX_DATA,
  input  logic                 RX_VALID,
  output logic                 RX_READY,
  output logic [STR_WIDTH-1:0] OUTSTR,
  output logic                 START,
  input  logic [1:0]           CONV_STATUS,
  output logic [7:0]           LINE_LEN,
  output logic                 OVERFLOW
);

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] WAIT    = 1'b1;
  localparam logic [7:0] STRLEN  = 8'(STR_WIDTH / 8);

  logic [0:0]           state_r, state_s;
  logic [STR_WIDTH-1:0] buf_r, buf_s;
  logic [7:0]           count_r, count_s;
  logic                 ovf_r, ovf_s;
  logic                 start_r, start_s;
  logic [7:0]           line_len_r, line_len_s;
  logic                 overflow_r, overflow_s;
  logic                 accept_s;

  function automatic logic is_eol(input logic [7:0] b);
    return (b == 8'h0D) || (b == 8'h0A);
  endfunction

  function automatic logic is_erase(input logic [7:0] b);
    return (b == 8'h08) || (b == 8'h7F);
  endfunction

  function automatic logic is_esc(input logic [7:0] b);
    return (b == 8'h1B);
  endfunction

  assign RX_READY = (state_r == COLLECT) && resetn;
  assign accept_s = RX_VALID && RX_READY;
  assign OUTSTR   = buf_r;
  assign START    = start_r;
  assign LINE_LEN = line_len_r;
  assign OVERFLOW = overflow_r;

  // Next-state computation for the collector FSM and line buffer.
  always_comb begin
    state_s    = state_r;
    buf_s      = buf_r;
    count_s    = count_r;
    ovf_s      = ovf_r;
    start_s    = 1'b0;
    line_len_s = line_len_r;
    overflow_s = overflow_r;
    case (state_r)
      COLLECT: begin
        if (accept_s) begin
          if (is_esc(RX_DATA)) begin
            buf_s   = '0;
            count_s = 8'd0;
            ovf_s   = 1'b0;
          end else if (is_eol(RX_DATA)) begin
            // Empty lines (e.g. the LF of a CR-LF pair) never strobe.
            if (count_r != 8'd0) begin
              start_s    = 1'b1;
              line_len_s = count_r;
              overflow_s = ovf_r;
              state_s    = WAIT;
            end else begin
              state_s = COLLECT;
            end
          end else if (is_erase(RX_DATA)) begin
            if (count_r != 8'd0) begin
              buf_s   = buf_r >> 8'd8;
              count_s = count_r - 8'd1;
            end else begin
              count_s = count_r;
            end
          end else if (count_r < STRLEN) begin
            buf_s       = buf_r << 8'd8;
            buf_s[7:0]  = RX_DATA;
            count_s     = count_r + 8'd1;
          end else begin
            ovf_s = 1'b1;
          end
        end else begin
          state_s = COLLECT;
        end
      end
      WAIT: begin
        // Status seen alongside START belongs to the previous conversion.
        if (!start_r && (CONV_STATUS != 2'd0)) begin
          buf_s   = '0;
          count_s = 8'd0;
          ovf_s   = 1'b0;
          state_s = COLLECT;
        end else begin
          state_s = WAIT;
        end
      end
      default: begin
        state_s = COLLECT;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r    <= COLLECT;
      buf_r      <= '0;
      count_r    <= 8'd0;
      ovf_r      <= 1'b0;
      start_r    <= 1'b0;
      line_len_r <= 8'd0;
      overflow_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      buf_r      <= buf_s;
      count_r    <= count_s;
      ovf_r      <= ovf_s;
      start_r    <= start_s;
      line_len_r <= line_len_s;
      overflow_r <= overflow_s;
    end
  end

endmodule

// File: tb/tb_line_collector.sv
// Self-checking bench for line_collector: directed line scenarios plus random
// byte streams compared against a queue-based model of the line editor.
module tb_line_collector;

  localparam int STR_WIDTH = 512;
  localparam int STRLEN    = STR_WIDTH / 8;

  logic                 clk = 1'b0;
  logic                 resetn = 1'b0;
  logic [7:0]           RX_DATA = 8'h00;
  logic                 RX_VALID = 1'b0;
  logic                 RX_READY;
  logic [STR_WIDTH-1:0] OUTSTR;
  logic                 START;
  logic [1:0]           CONV_STATUS = 2'd0;
  logic [7:0]           LINE_LEN;
  logic                 OVERFLOW;

  int checks = 0;
  int errors = 0;

  logic [7:0]   mq[$];
  bit           movf = 1'b0;
  bit           emitted;
  logic [511:0] exp_str;
  logic [7:0]   exp_len;
  logic         exp_ovf;

  line_collector #(.STR_WIDTH(STR_WIDTH)) dut (
    .clk(clk), .resetn(resetn), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .RX_READY(RX_READY), .OUTSTR(OUTSTR), .START(START),
    .CONV_STATUS(CONV_STATUS), .LINE_LEN(LINE_LEN), .OVERFLOW(OVERFLOW)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] pack();
    logic [511:0] r = '0;
    foreach (mq[i]) r = (r << 8) | 512'(mq[i]);
    return r;
  endfunction

  // Line-editor rules applied to the model queue.
  task automatic model_push(input logic [7:0] b);
    emitted = 1'b0;
    if (b == 8'h1B) begin
      mq.delete();
      movf = 1'b0;
    end else if (b == 8'h0D || b == 8'h0A) begin
      if (mq.size() > 0) begin
        emitted = 1'b1;
        exp_str = pack();
        exp_len = 8'(mq.size());
        exp_ovf = movf;
        mq.delete();
        movf = 1'b0;
      end
    end else if (b == 8'h08 || b == 8'h7F) begin
      if (mq.size() > 0) void'(mq.pop_back());
    end else if (mq.size() < STRLEN) begin
      mq.push_back(b);
    end else begin
      movf = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    chk("rx_ready_before_send", {511'd0, RX_READY}, 512'd1);
    model_push(b);
    RX_DATA  = b;
    RX_VALID = 1'b1;
    tick();
    RX_VALID = 1'b0;
    if (emitted) begin
      chk("start_strobe", {511'd0, START}, 512'd1);
      chk("outstr_line", OUTSTR, exp_str);
      chk("line_len", {504'd0, LINE_LEN}, {504'd0, exp_len});
      chk("overflow", {511'd0, OVERFLOW}, {511'd0, exp_ovf});
      chk("rx_ready_in_wait", {511'd0, RX_READY}, 512'd0);
    end else begin
      chk("no_start", {511'd0, START}, 512'd0);
      chk("rx_ready_collect", {511'd0, RX_READY}, 512'd1);
      chk("outstr_buffer", OUTSTR, pack());
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic finish_line(input int dly, input logic [1:0] st);
    tick();
    chk("start_one_cycle", {511'd0, START}, 512'd0);
    chk("wait_not_ready", {511'd0, RX_READY}, 512'd0);
    chk("outstr_hold", OUTSTR, exp_str);
    for (int i = 0; i < dly; i++) begin
      tick();
      chk("wait_hold_ready", {511'd0, RX_READY}, 512'd0);
      chk("wait_hold_outstr", OUTSTR, exp_str);
    end
    CONV_STATUS = st;
    tick();
    CONV_STATUS = 2'd0;
    chk("turnaround_ready", {511'd0, RX_READY}, 512'd1);
    chk("cleared_outstr", OUTSTR, 512'd0);
    chk("len_held", {504'd0, LINE_LEN}, {504'd0, exp_len});
    chk("ovf_held", {511'd0, OVERFLOW}, {511'd0, exp_ovf});
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    chk("rst_ready", {511'd0, RX_READY}, 512'd0);
    chk("rst_start", {511'd0, START}, 512'd0);
    chk("rst_outstr", OUTSTR, 512'd0);
    chk("rst_len", {504'd0, LINE_LEN}, 512'd0);
    chk("rst_ovf", {511'd0, OVERFLOW}, 512'd0);
    resetn = 1'b1;
    RX_VALID = 1'b0;
    mq.delete();
    movf = 1'b0;
    #1;
    chk("rst_release_ready", {511'd0, RX_READY}, 512'd1);
  endtask

  initial begin
    logic [7:0] b;
    logic [511:0] all_a;
    all_a = {64{8'h41}};

    tick();
    do_reset();

    // "123\r" with a status pulse during the START cycle that must be ignored.
    send_str("123");
    send_byte(8'h0D);
    chk("l123_outstr", OUTSTR, 512'h313233);
    chk("l123_len", {504'd0, LINE_LEN}, 512'd3);
    CONV_STATUS = 2'd2;
    tick();
    CONV_STATUS = 2'd0;
    chk("status_ignored_on_start", {511'd0, RX_READY}, 512'd0);
    finish_line(2, 2'd3);

    // Empty terminators, then one line from a CR-LF pair.
    send_byte(8'h0D); send_byte(8'h0A); send_byte(8'h0D); send_byte(8'h0A);
    send_str("7");
    send_byte(8'h0D);
    chk("l7_outstr", OUTSTR, 512'h37);
    finish_line(0, 2'd1);
    send_byte(8'h0A);

    // Backspace edit.
    send_str("0x1G");
    send_byte(8'h08);
    send_str("F");
    send_byte(8'h0A);
    chk("edit_outstr", OUTSTR, 512'h30783146);
    chk("edit_len", {504'd0, LINE_LEN}, 512'd4);
    finish_line(1, 2'd2);

    // Overflow: 70 characters into a 64-byte buffer.
    for (int i = 0; i < 70; i++) send_byte(8'h41);
    send_byte(8'h0A);
    chk("ovf_outstr", OUTSTR, all_a);
    chk("ovf_len", {504'd0, LINE_LEN}, 512'd64);
    chk("ovf_flag", {511'd0, OVERFLOW}, 512'd1);
    finish_line(0, 2'd3);
    send_str("5");
    send_byte(8'h0D);
    chk("ovf_cleared", {511'd0, OVERFLOW}, 512'd0);
    finish_line(0, 2'd3);

    // ESC discards the partial line.
    send_str("12");
    send_byte(8'h1B);
    send_str("9");
    send_byte(8'h0D);
    chk("esc_outstr", OUTSTR, 512'h39);
    chk("esc_len", {504'd0, LINE_LEN}, 512'd1);
    finish_line(0, 2'd1);

    // Reset while in WAIT with a byte held valid.
    send_str("AB");
    send_byte(8'h0D);
    tick();
    RX_DATA  = 8'h5A;
    RX_VALID = 1'b1;
    tick();
    chk("wait_byte_not_taken", OUTSTR, 512'h4142);
    do_reset();

    // Reset mid-line: the pending line must never strobe.
    send_str("AB");
    do_reset();
    send_byte(8'h0D);

    // Random byte stream against the model.
    for (int n = 0; n < 400; n++) begin
      int r;
      r = int'($urandom_range(0, 24));
      case (r)
        0: b = 8'h0D;
        1: b = 8'h0A;
        2: b = 8'h08;
        3: b = 8'h7F;
        4: b = (($urandom_range(0, 3) == 0) ? 8'h1B : 8'h41);
        5: b = 8'($urandom_range(0, 255));
        default: b = 8'($urandom_range(32, 126));
      endcase
      send_byte(b);
      if (emitted) finish_line(int'($urandom_range(0, 3)), 2'($urandom_range(1, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
